// File: rtl/ir_pkg.sv
// Shared definitions for the IR reflectance-sensor emulator and the benches that drive it.
// Holds channel-FSM encoding, geometry constants and the reader's charge/sample timing.
package ir_pkg;
   localparam int NCH        = 8;
   localparam int DW         = 16;
   localparam int LOW_CYC    = 2;
   localparam int CHARGE_CYC = 501;
   localparam int SAMPLE_CYC = 10503;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HOLD     = 2'd1,
      ST_WAIT_LOW = 2'd2
   } ch_state_e;
endpackage

// File: rtl/ir_sensor_emulator_if.sv
// Decay-register write port: single-cycle strobe, channel select and decay value.
// Writes land at the next edge, with no backpressure.
interface ir_sensor_emulator_if #(
   parameter int DW = ir_pkg::DW,
   parameter int SW = $clog2(ir_pkg::NCH)
);
   logic          cfg_wr;
   logic [SW-1:0] cfg_sel;
   logic [DW-1:0] cfg_data;

   modport master (output cfg_wr, cfg_sel, cfg_data);
   modport slave  (input  cfg_wr, cfg_sel, cfg_data);
endinterface

// File: rtl/ir_channel_emu.sv
// One emulated RC sensor line. The line is driven 3 clk after the pin rises and is held for exactly decay cycles.
// A new edge is ignored until the line has been sampled low for LOW_CYC consecutive cycles.
module ir_channel_emu
   import ir_pkg::*;
#(
   parameter int DW      = ir_pkg::DW,
   parameter int LOW_CYC = ir_pkg::LOW_CYC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          line_in,
   input  logic [DW-1:0] decay,
   output logic          oe,
   output logic          busy,
   output logic          trig
);
   localparam int LW = $clog2(LOW_CYC + 1);

   logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   ch_state_e     state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] low_q, low_d;
   logic          oe_q, oe_d;
   logic          rise;

   always_comb begin
      s1_d = line_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   assign rise = s2_q & ~s3_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      low_d   = low_q;
      oe_d    = 1'b0;
      trig    = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         low_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  trig  = 1'b1;
                  low_d = '0;
                  // Zero decay emulates a white surface: never drive, just wait for release.
                  if (decay == '0) begin
                     state_d = ST_WAIT_LOW;
                  end else begin
                     state_d = ST_HOLD;
                     cnt_d   = decay - DW'(1);
                     oe_d    = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  state_d = ST_WAIT_LOW;
               end else begin
                  cnt_d = cnt_q - DW'(1);
                  oe_d  = 1'b1;
               end
            end
            ST_WAIT_LOW: begin
               if (s2_q) begin
                  low_d = '0;
               end else if (low_q == LW'(LOW_CYC - 1)) begin
                  state_d = ST_IDLE;
                  low_d   = '0;
               end else begin
                  low_d = low_q + LW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         low_q   <= '0;
         oe_q    <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         low_q   <= low_d;
         oe_q    <= oe_d;
      end
   end

   assign oe   = oe_q;
   assign busy = (state_q == ST_HOLD);
endmodule

// File: rtl/ir_sensor_emulator.sv
// 8-channel RC reflectance sensor bar stand-in: decay register file, channel-0 trigger counter and open-high line drivers.
// Lines are driven 3 clk after a charge edge; the block only ever drives 1 or Z, so the reader is never fought.
module ir_sensor_emulator
   import ir_pkg::*;
#(
   parameter int NCH     = ir_pkg::NCH,
   parameter int DW      = ir_pkg::DW,
   parameter int LOW_CYC = ir_pkg::LOW_CYC
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   ir_sensor_emulator_if.slave  cfg,
   inout  wire  [NCH-1:0]       ir_line,
   output logic [NCH-1:0]       busy,
   output logic [15:0]          trig_cnt
);
   // Only channel 0 feeds the trigger counter.
   localparam logic [NCH-1:0] TRIG_MASK = NCH'(1);

   logic [DW-1:0]  decay_q [NCH];
   logic [DW-1:0]  decay_d [NCH];
   logic [15:0]    trig_cnt_q, trig_cnt_d;
   logic [NCH-1:0] oe;
   logic [NCH-1:0] trig;

   always_comb begin
      decay_d = decay_q;
      if (cfg.cfg_wr) begin
         decay_d[cfg.cfg_sel] = cfg.cfg_data;
      end
   end

   always_comb begin
      trig_cnt_d = trig_cnt_q + 16'(|(trig & TRIG_MASK));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            decay_q[i] <= '0;
         end
         trig_cnt_q <= '0;
      end else begin
         decay_q    <= decay_d;
         trig_cnt_q <= trig_cnt_d;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ir_channel_emu #(
         .DW      (DW),
         .LOW_CYC (LOW_CYC)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .enable  (enable),
         .line_in (ir_line[i]),
         .decay   (decay_q[i]),
         .oe      (oe[i]),
         .busy    (busy[i]),
         .trig    (trig[i])
      );
      assign ir_line[i] = oe[i] ? 1'b1 : 1'bz;
   end

   assign trig_cnt = trig_cnt_q;
endmodule
